alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-op RV32I ALU, between the ALU reservation station and the common data bus (CDB).
- Accepts one issued op per cycle over a valid/ready handshake and computes all RV32I integer/branch/jump/upper-immediate ops, with correct arithmetic shifts and signed compares.
- Buffers results in a small output FIFO until the CDB arbiter grants. Supports a ROB flush on mispredict.

---
 rtl/alu_pipe.sv | 379 +++++++++++++++++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- pipelined RV32I/RV64I integer ALU feeding the common data bus.
//
// Accepts one issued op per cycle (valid/ready), computes every integer,
// branch, jump and upper-immediate op, and queues results in a small
// in-order output FIFO until the CDB arbiter grants. A ROB flush empties
// both the pipeline and the FIFO.
//
// Parameters:
//   XLEN      datapath width (32 or 64)
//   TAG_W     ROB tag width
//   STAGES    compute latency, 1 or 2 (2 adds a register between
//             decode/compare and the result mux)
//   OUT_DEPTH output FIFO entries (>= 1)
//
// Ports:
//   clk_in, rst_in (synchronous, active-high), rdy_in (low freezes all state),
//   flush (ROB mispredict)
//   in_valid/in_ready issue handshake; in_opcode, in_funct3, in_funct7b5,
//   in_vj, in_vk, in_imm, in_pc, in_tag describe the op
//   cdb_valid/cdb_grant head handshake; cdb_tag, cdb_result, cdb_jump,
//   cdb_pc_out describe the head entry (all zero while the FIFO is empty)
//
// Optional feature (macro ALU_PERF_CNT_EN): saturating 32-bit counters
//   perf_ops (accepts), perf_taken (pops with jump=1),
//   perf_stall (cycles with in_valid && !in_ready && rdy_in).
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 4,
  parameter int STAGES    = 2,
  parameter int OUT_DEPTH = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [XLEN-1:0]  in_vj,
  input  logic [XLEN-1:0]  in_vk,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             cdb_valid,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_result,
  output logic             cdb_jump,
  output logic [XLEN-1:0]  cdb_pc_out
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_taken,
  output logic [31:0]      perf_stall
`endif
);

  localparam int SHW   = $clog2(XLEN);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int CRD_W = CNT_W + 1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Result source selected in the second half of the pipe.
  localparam logic [1:0] K_ZERO  = 2'd0;  // branches and undefined ops
  localparam logic [1:0] K_ALU   = 2'd1;
  localparam logic [1:0] K_UPPER = 2'd2;  // LUI / AUIPC
  localparam logic [1:0] K_LINK  = 2'd3;  // JAL / JALR return address

  typedef struct packed {
    logic [1:0]       kind;
    logic [2:0]       funct3;
    logic             alt;     // SUB for OP add, arithmetic for right shifts
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic             lts;
    logic             ltu;
    logic             jump;
    logic [XLEN-1:0]  link;    // pc+4
    logic [XLEN-1:0]  tgt;     // control-transfer target
    logic [XLEN-1:0]  upper;   // LUI / AUIPC result
    logic [TAG_W-1:0] tag;
  } dec_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  result;
    logic             jump;
    logic [XLEN-1:0]  pc_out;
  } ent_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1'b1);
  endfunction

  // ---------------------------------------------------------------------------
  // Issue handshake and credit
  // ---------------------------------------------------------------------------
  logic             accept_s;
  logic             inflight_s;
  logic [CRD_W-1:0] credit_used_s;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  // Credit covers both queued entries and ops still in the pipe, so a push
  // never finds the FIFO full even without a same-cycle pop.
  assign credit_used_s = CRD_W'(count_q) + CRD_W'(inflight_s);
  assign in_ready      = !rst_in && rdy_in && (credit_used_s < CRD_W'(OUT_DEPTH));
  assign accept_s      = in_valid && in_ready && !flush;

  // ---------------------------------------------------------------------------
  // Decode / compare
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] opb_s, pc_imm_s, pc4_s, jalr_sum_s;
  logic            cmp_lts_s, cmp_ltu_s, cmp_eq_s, br_taken_s;
  dec_t            dec_s;

  // Register-register ops and branches compare rs1 with rs2, the rest with imm.
  assign opb_s      = ((in_opcode == OPC_OP) || (in_opcode == OPC_BRANCH)) ? in_vk : in_imm;
  assign pc_imm_s   = in_pc + in_imm;
  assign pc4_s      = in_pc + {{(XLEN-3){1'b0}}, 3'b100};
  assign jalr_sum_s = in_vj + in_imm;
  assign cmp_lts_s  = $signed(in_vj) < $signed(opb_s);
  assign cmp_ltu_s  = in_vj < opb_s;
  assign cmp_eq_s   = in_vj == opb_s;

  // Branch outcome by funct3; reserved encodings never take.
  always_comb begin
    case (in_funct3)
      3'b000:  br_taken_s = cmp_eq_s;
      3'b001:  br_taken_s = !cmp_eq_s;
      3'b100:  br_taken_s = cmp_lts_s;
      3'b101:  br_taken_s = !cmp_lts_s;
      3'b110:  br_taken_s = cmp_ltu_s;
      3'b111:  br_taken_s = !cmp_ltu_s;
      default: br_taken_s = 1'b0;
    endcase
  end

  // Classify the op and precompute targets; unknown opcodes fall to K_ZERO.
  always_comb begin
    dec_s        = '0;
    dec_s.funct3 = in_funct3;
    dec_s.a      = in_vj;
    dec_s.b      = opb_s;
    dec_s.lts    = cmp_lts_s;
    dec_s.ltu    = cmp_ltu_s;
    dec_s.link   = pc4_s;
    dec_s.tag    = in_tag;
    case (in_opcode)
      OPC_OP: begin
        dec_s.kind = K_ALU;
        dec_s.alt  = in_funct7b5;
      end
      OPC_OPIMM: begin
        dec_s.kind = K_ALU;
        // instr[30] is an immediate bit for ADDI; only SRAI uses it as a select.
        dec_s.alt  = (in_funct3 == 3'b101) ? in_funct7b5 : 1'b0;
      end
      OPC_LUI: begin
        dec_s.kind  = K_UPPER;
        dec_s.upper = in_imm;
      end
      OPC_AUIPC: begin
        dec_s.kind  = K_UPPER;
        dec_s.upper = pc_imm_s;
      end
      OPC_JAL: begin
        dec_s.kind = K_LINK;
        dec_s.jump = 1'b1;
        dec_s.tgt  = pc_imm_s;
      end
      OPC_JALR: begin
        if (in_funct3 == 3'b000) begin
          dec_s.kind = K_LINK;
          dec_s.jump = 1'b1;
          dec_s.tgt  = {jalr_sum_s[XLEN-1:1], 1'b0};
        end else begin
          dec_s.kind = K_ZERO;
        end
      end
      OPC_BRANCH: begin
        dec_s.kind = K_ZERO;
        dec_s.jump = br_taken_s;
        dec_s.tgt  = pc_imm_s;
      end
      default: begin
        dec_s.kind = K_ZERO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional pipeline register
  // ---------------------------------------------------------------------------
  dec_t dec_b_s;
  logic vld_b_s;

  generate
    if (STAGES >= 2) begin : g_two_stage
      dec_t stage_q;
      logic stage_vld_q;

      // Decode/compare register; emptied by flush, held while rdy_in is low.
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          stage_vld_q <= 1'b0;
          stage_q     <= '0;
        end else if (rdy_in) begin
          stage_vld_q <= accept_s;
          if (accept_s) begin
            stage_q <= dec_s;
          end else begin
            stage_q <= stage_q;
          end
        end else begin
          stage_vld_q <= stage_vld_q;
          stage_q     <= stage_q;
        end
      end

      assign dec_b_s    = stage_q;
      assign vld_b_s    = stage_vld_q;
      assign inflight_s = stage_vld_q;
    end else begin : g_one_stage
      assign dec_b_s    = dec_s;
      assign vld_b_s    = accept_s;
      assign inflight_s = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Result mux
  // ---------------------------------------------------------------------------
  logic [SHW-1:0]  shamt_s;
  logic [XLEN-1:0] sll_s, srl_s, sra_s, alu_s;
  ent_t            ent_s;

  assign shamt_s = dec_b_s.b[SHW-1:0];
  assign sll_s   = dec_b_s.a << shamt_s;
  assign srl_s   = dec_b_s.a >> shamt_s;
  // Kept in its own assignment so the signed context is not lost in a mux.
  assign sra_s   = $signed(dec_b_s.a) >>> shamt_s;

  // Integer op select.
  always_comb begin
    case (dec_b_s.funct3)
      3'b000:  alu_s = dec_b_s.alt ? (dec_b_s.a - dec_b_s.b) : (dec_b_s.a + dec_b_s.b);
      3'b001:  alu_s = sll_s;
      3'b010:  alu_s = {{(XLEN-1){1'b0}}, dec_b_s.lts};
      3'b011:  alu_s = {{(XLEN-1){1'b0}}, dec_b_s.ltu};
      3'b100:  alu_s = dec_b_s.a ^ dec_b_s.b;
      3'b101:  alu_s = dec_b_s.alt ? sra_s : srl_s;
      3'b110:  alu_s = dec_b_s.a | dec_b_s.b;
      3'b111:  alu_s = dec_b_s.a & dec_b_s.b;
      default: alu_s = {XLEN{1'b0}};
    endcase
  end

  // Assemble the FIFO entry.
  always_comb begin
    ent_s        = '0;
    ent_s.tag    = dec_b_s.tag;
    ent_s.jump   = dec_b_s.jump;
    ent_s.pc_out = dec_b_s.jump ? dec_b_s.tgt : dec_b_s.link;
    case (dec_b_s.kind)
      K_ALU:   ent_s.result = alu_s;
      K_UPPER: ent_s.result = dec_b_s.upper;
      K_LINK:  ent_s.result = dec_b_s.link;
      default: ent_s.result = {XLEN{1'b0}};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  ent_t mem_q [OUT_DEPTH];
  ent_t head_s;
  logic push_s, pop_s;

  assign head_s    = mem_q[rd_ptr_q];
  assign cdb_valid = (count_q != {CNT_W{1'b0}});
  // Flush wins over both the push from the pipe and a grant.
  assign push_s    = vld_b_s && rdy_in && !flush;
  assign pop_s     = cdb_grant && rdy_in && !flush && cdb_valid;

  // Next-state for FIFO pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rdy_in && flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk_in) begin
    if (!rst_in && push_s) begin
      mem_q[wr_ptr_q] <= ent_s;
    end
  end

  // Head entry presented only while valid so an empty FIFO drives zeros.
  assign cdb_tag    = cdb_valid ? head_s.tag    : {TAG_W{1'b0}};
  assign cdb_result = cdb_valid ? head_s.result : {XLEN{1'b0}};
  assign cdb_jump   = cdb_valid ? head_s.jump   : 1'b0;
  assign cdb_pc_out = cdb_valid ? head_s.pc_out : {XLEN{1'b0}};

`ifdef ALU_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic [31:0] perf_ops_q, perf_taken_q, perf_stall_q;
  logic        stall_s;

  assign stall_s = in_valid && !in_ready && rdy_in;

  // Saturating event counters; survive flush, freeze with rdy_in.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_ops_q   <= 32'd0;
      perf_taken_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else if (rdy_in) begin
      perf_ops_q   <= accept_s ? sat_inc(perf_ops_q) : perf_ops_q;
      perf_taken_q <= (pop_s && head_s.jump) ? sat_inc(perf_taken_q) : perf_taken_q;
      perf_stall_q <= stall_s ? sat_inc(perf_stall_q) : perf_stall_q;
    end else begin
      perf_ops_q   <= perf_ops_q;
      perf_taken_q <= perf_taken_q;
      perf_stall_q <= perf_stall_q;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_taken = perf_taken_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe -- self-checking bench for alu_pipe (XLEN=32, STAGES=2,
// OUT_DEPTH=2). Directed op vectors with hand-computed results, then
// hand-written sequences for back-pressure, flush and rdy_in freeze.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JLR = 7'b1100111;
  localparam logic [6:0] BR  = 7'b1100011;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush, in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_vj, in_vk, in_imm, in_pc;
  logic [3:0]  in_tag;
  logic        cdb_valid, cdb_grant, cdb_jump;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_result, cdb_pc_out;
`ifdef ALU_PERF_CNT_EN
  logic [31:0] perf_ops, perf_taken, perf_stall;
  logic [31:0] stall0;
`endif

  alu_pipe #(.XLEN(32), .TAG_W(4), .STAGES(2), .OUT_DEPTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_vj(in_vj),
    .in_vk(in_vk), .in_imm(in_imm), .in_pc(in_pc), .in_tag(in_tag),
    .cdb_valid(cdb_valid), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag),
    .cdb_result(cdb_result), .cdb_jump(cdb_jump), .cdb_pc_out(cdb_pc_out)
`ifdef ALU_PERF_CNT_EN
    , .perf_ops(perf_ops), .perf_taken(perf_taken), .perf_stall(perf_stall)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] vj, vk, imm, pc;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        jmp;
    logic [31:0] pco;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] got_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add_vec(input string name, input logic [6:0] opc, input logic [2:0] f3,
                         input logic f7, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag,
                         input logic [31:0] res, input logic jmp, input logic [31:0] pco);
    vec_t v;
    v.name = name; v.opc = opc; v.f3 = f3; v.f7 = f7; v.vj = vj; v.vk = vk;
    v.imm = imm; v.pc = pc; v.tag = tag; v.res = res; v.jmp = jmp; v.pco = pco;
    vecs.push_back(v);
  endtask

  task automatic set_add(input logic [3:0] tag);
    in_opcode = OP; in_funct3 = 3'd0; in_funct7b5 = 1'b0;
    in_vj = 32'd100; in_vk = {28'd0, tag}; in_imm = 32'd0; in_pc = 32'd0; in_tag = tag;
  endtask

  // Pops with grant held, records delivered tags, drops in_valid once accepted.
  task automatic drain(input int max_cycles);
    logic acc;
    got_q.delete();
    for (int c = 0; c < max_cycles; c++) begin
      if (cdb_valid && cdb_grant && rdy_in) got_q.push_back(cdb_tag);
      acc = in_valid && in_ready;
      @(posedge clk_in); #1;
      if (acc) in_valid = 1'b0;
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; in_valid = 1'b0; cdb_grant = 1'b1;
    set_add(4'd0);

    //        name      opc  f3    f7    vj            vk            imm           pc            tag    res           jmp   pc_out
    add_vec("add",     OP,  3'd0, 1'b0, 32'd5,        32'd7,        32'd0,        32'h0,        4'd3,  32'd12,       1'b0, 32'h4);
    add_vec("sra",     OP,  3'd5, 1'b1, 32'h80000010, 32'd4,        32'd0,        32'h0,        4'd1,  32'hF8000001, 1'b0, 32'h4);
    add_vec("srl",     OP,  3'd5, 1'b0, 32'h80000010, 32'd4,        32'd0,        32'h0,        4'd2,  32'h08000001, 1'b0, 32'h4);
    add_vec("slt",     OP,  3'd2, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,        4'd4,  32'd1,        1'b0, 32'h4);
    add_vec("sltu",    OP,  3'd3, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,        4'd5,  32'd0,        1'b0, 32'h4);
    add_vec("sub",     OP,  3'd0, 1'b1, 32'd3,        32'd5,        32'd0,        32'h0,        4'd6,  32'hFFFFFFFE, 1'b0, 32'h4);
    add_vec("addwrap", OP,  3'd0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,        4'd7,  32'd0,        1'b0, 32'h4);
    add_vec("sll",     OP,  3'd1, 1'b0, 32'd1,        32'h23,       32'd0,        32'h0,        4'd8,  32'd8,        1'b0, 32'h4);
    add_vec("xor",     OP,  3'd4, 1'b0, 32'hF0F0,     32'hFF00,     32'd0,        32'h0,        4'd9,  32'h0FF0,     1'b0, 32'h4);
    add_vec("and",     OP,  3'd7, 1'b0, 32'hF0F0,     32'hFF00,     32'd0,        32'h0,        4'd10, 32'hF000,     1'b0, 32'h4);
    add_vec("or",      OP,  3'd6, 1'b0, 32'hF0F0,     32'hFF00,     32'd0,        32'h0,        4'd11, 32'hFFF0,     1'b0, 32'h4);
    add_vec("addi_b30",OPI, 3'd0, 1'b1, 32'd1,        32'd99,       32'h400,      32'h0,        4'd12, 32'h401,      1'b0, 32'h4);
    add_vec("srai31",  OPI, 3'd5, 1'b1, 32'h80000000, 32'd0,        32'h41F,      32'h0,        4'd13, 32'hFFFFFFFF, 1'b0, 32'h4);
    add_vec("slti",    OPI, 3'd2, 1'b0, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF, 32'h0,        4'd14, 32'd1,        1'b0, 32'h4);
    add_vec("lui",     LUI, 3'd0, 1'b0, 32'd9,        32'd9,        32'h12345000, 32'h200,      4'd15, 32'h12345000, 1'b0, 32'h204);
    add_vec("auipc",   AUI, 3'd0, 1'b0, 32'd0,        32'd0,        32'h2000,     32'h1000,     4'd0,  32'h3000,     1'b0, 32'h1004);
    add_vec("jal",     JAL, 3'd0, 1'b0, 32'd0,        32'd0,        32'hFFFFFFF8, 32'h40,       4'd1,  32'h44,       1'b1, 32'h38);
    add_vec("jalr",    JLR, 3'd0, 1'b0, 32'h1001,     32'd0,        32'd2,        32'h40,       4'd2,  32'h44,       1'b1, 32'h1002);
    add_vec("jalr_bad",JLR, 3'd1, 1'b0, 32'h1001,     32'd0,        32'd2,        32'h40,       4'd3,  32'd0,        1'b0, 32'h44);
    add_vec("blt",     BR,  3'd4, 1'b0, 32'hFFFFFFFD, 32'd2,        32'h20,       32'h100,      4'd4,  32'd0,        1'b1, 32'h120);
    add_vec("bgeu",    BR,  3'd7, 1'b0, 32'hFFFFFFFD, 32'd2,        32'h20,       32'h100,      4'd5,  32'd0,        1'b1, 32'h120);
    add_vec("bge",     BR,  3'd5, 1'b0, 32'hFFFFFFFD, 32'd2,        32'h20,       32'h100,      4'd6,  32'd0,        1'b0, 32'h104);
    add_vec("bltu",    BR,  3'd6, 1'b0, 32'hFFFFFFFD, 32'd2,        32'h20,       32'h100,      4'd7,  32'd0,        1'b0, 32'h104);
    add_vec("beq",     BR,  3'd0, 1'b0, 32'd4,        32'd5,        32'h20,       32'h100,      4'd8,  32'd0,        1'b0, 32'h104);
    add_vec("bne",     BR,  3'd1, 1'b0, 32'd4,        32'd5,        32'h20,       32'h100,      4'd9,  32'd0,        1'b1, 32'h120);
    add_vec("br_f3_2", BR,  3'd2, 1'b0, 32'd4,        32'd4,        32'h20,       32'h100,      4'd10, 32'd0,        1'b0, 32'h104);
    add_vec("undef",   7'd0,3'd0, 1'b0, 32'd5,        32'd7,        32'd0,        32'h80,       4'd11, 32'd0,        1'b0, 32'h84);

    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valid", cdb_valid, 0);
    chk("rst_tag", cdb_tag, 0);
    chk("rst_result", cdb_result, 0);
    chk("rst_jump", cdb_jump, 0);
    chk("rst_pc_out", cdb_pc_out, 0);
    rst_in = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1);

    // Directed op vectors: issue one op, look at the head exactly STAGES later.
    @(posedge clk_in); #1;
    foreach (vecs[i]) begin
      in_opcode = vecs[i].opc; in_funct3 = vecs[i].f3; in_funct7b5 = vecs[i].f7;
      in_vj = vecs[i].vj; in_vk = vecs[i].vk; in_imm = vecs[i].imm;
      in_pc = vecs[i].pc; in_tag = vecs[i].tag; in_valid = 1'b1;
      @(posedge clk_in); #1;
      in_valid = 1'b0;
      @(posedge clk_in); #1;
      chk({vecs[i].name, "_valid"}, cdb_valid, 1);
      chk({vecs[i].name, "_tag"}, cdb_tag, vecs[i].tag);
      chk({vecs[i].name, "_result"}, cdb_result, vecs[i].res);
      chk({vecs[i].name, "_jump"}, cdb_jump, vecs[i].jmp);
      chk({vecs[i].name, "_pc_out"}, cdb_pc_out, vecs[i].pco);
      @(posedge clk_in); #1;
    end

    // Back-pressure: no grant, in_valid held -> exactly OUT_DEPTH accepts.
    begin
      int n_acc = 0;
      logic acc;
`ifdef ALU_PERF_CNT_EN
      stall0 = perf_stall;
`endif
      cdb_grant = 1'b0;
      set_add(4'd8);
      in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
        acc = in_ready;
        if (acc) n_acc++;
        @(posedge clk_in); #1;
        if (acc) set_add(in_tag + 4'd1);
      end
      chk("bp_accepts", n_acc, 2);
      chk("bp_ready_low", in_ready, 0);
      chk("bp_head_tag", cdb_tag, 8);
`ifdef ALU_PERF_CNT_EN
      chk("bp_perf_stall", perf_stall - stall0, 4);
`endif
      cdb_grant = 1'b1;
      @(posedge clk_in); #1;
      cdb_grant = 1'b0;
      chk("bp_ready_back", in_ready, 1);
      chk("bp_next_head", cdb_tag, 9);
      @(posedge clk_in); #1;
      in_valid = 1'b0;
      cdb_grant = 1'b1;
      drain(8);
      chk("bp_drain_n", got_q.size(), 2);
      if (got_q.size() == 2) begin
        chk("bp_order0", got_q[0], 9);
        chk("bp_order1", got_q[1], 10);
      end
    end

    // Flush with one entry queued and one in flight; nothing is delivered.
    cdb_grant = 1'b0;
    set_add(4'd11);
    in_valid = 1'b1;
    @(posedge clk_in); #1;
    set_add(4'd12);
    @(posedge clk_in); #1;
    chk("fl_setup_valid", cdb_valid, 1);
    set_add(4'd13);
    flush = 1'b1;
    @(posedge clk_in); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid_low", cdb_valid, 0);
    chk("fl_ready", in_ready, 1);
    cdb_grant = 1'b1;
    drain(6);
    chk("fl_delivered", got_q.size(), 0);

    // Flush beats a same-cycle accept into an empty block.
    set_add(4'd14);
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk_in); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    drain(5);
    chk("fl_accept_dropped", got_q.size(), 0);

    // rdy_in low for 3 cycles: head, in-flight op and pending op all hold.
    cdb_grant = 1'b0;
    set_add(4'd5);
    in_valid = 1'b1;
    @(posedge clk_in); #1;
    set_add(4'd6);
    @(posedge clk_in); #1;
    set_add(4'd7);
    rdy_in = 1'b0;
    cdb_grant = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("frz_ready", in_ready, 0);
      chk("frz_valid", cdb_valid, 1);
      chk("frz_tag", cdb_tag, 5);
      @(posedge clk_in); #1;
    end
    rdy_in = 1'b1;
    drain(10);
    chk("frz_accept_resumed", in_valid, 0);
    chk("frz_drain_n", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("frz_order0", got_q[0], 5);
      chk("frz_order1", got_q[1], 6);
      chk("frz_order2", got_q[2], 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
